instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's instruction decoder: encodes field-level instruction requests (kind, registers, funct3, immediate) into 32-bit RV32I words for the supported subset (lw, sw, R-type, beq-class branch, addi-class op-imm, jal, jalr).
- Writes the encoded words sequentially into instruction memory through a single write port.
- Used as a synthesizable program loader for bring-up and as a stimulus source for decoder/core regression.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction-memory write port (depth 2^ADDR_WIDTH words).
- BASE_ADDR, 0, first word address written after each start.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a new program load; honoured only in IDLE or ERR.
- in_valid  input  1  request beat valid.
- in_ready  output  1  encoder accepts a beat this cycle.
- in_kind  input  3  0 LOAD, 1 STORE, 2 OP, 3 BRANCH, 4 OP_IMM, 5 JAL, 6 JALR, 7 illegal.
- in_rd / in_rs1 / in_rs2  input  5 each  register indices; fields unused by the format are ignored.
- in_funct3  input  3  funct3 for LOAD/STORE/OP/BRANCH/OP_IMM. Forced to 000 for JALR.
- in_sub  input  1  OP only: drives funct7[5] (sub/sra); other funct7 bits are 0.
- in_imm  input  32  signed byte-offset immediate.
- in_last  input  1  marks the final beat of the program.
- imem_we  output  1  one-cycle write strobe.
- imem_addr  output  ADDR_WIDTH  word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  high in LOAD and FLUSH.
- done  output  1  one-cycle pulse after the last write.
- err  output  1  sticky error flag; cleared only by start or reset.
- count  output  ADDR_WIDTH+1  number of words written since the last start.

Behaviour:
- Reset values: state IDLE; in_ready, imem_we, busy, done, err all 0; imem_addr = BASE_ADDR; imem_wdata = 0; count = 0.
- FSM states: IDLE, LOAD, FLUSH, DONE, ERR.
  - IDLE: start -> LOAD; addr = BASE_ADDR; count = 0; err cleared.
  - LOAD: in_ready = 1. A beat is accepted on in_valid && in_ready.
    - Legal beat: encoded word is registered. Next cycle imem_we = 1 with that word and the current addr (1-cycle latency). addr and count then increment.
    - Legal beat with in_last -> FLUSH.
  - FLUSH: the final write is issued; in_ready = 0 -> DONE.
  - DONE: done = 1 for one cycle -> IDLE.
  - ERR: in_ready = 0; imem_we = 0; start -> LOAD, as from IDLE.
- Back-to-back accepted beats produce back-to-back writes. Throughput is 1 word/cycle.
- start in LOAD, FLUSH or DONE is ignored.
- Encodings: LOAD 0000011 I-type; STORE 0100011 S-type; OP 0110011 R-type; BRANCH 1100011 B-type; OP_IMM 0010011 I-type; JAL 1101111 J-type; JALR 1100111 I-type.
- Immediate legality:
  - I and S formats: -2048..2047.
  - B format: -4096..4094, bit0 = 0.
  - J format: -1048576..1048574, bit0 = 0.
- Error beat (illegal kind, out-of-range immediate, or misaligned immediate):
  - The beat is consumed; no write is issued for it.
  - err is set and the FSM goes to ERR.
  - A write already in flight from the previous beat still completes.
- Wrap-around: a legal non-last beat accepted when addr = 2^ADDR_WIDTH-1 is written, then the block sets err and enters ERR; addr does not wrap. The same beat with in_last completes normally.
- Reset mid-operation: asynchronous return to reset values; a pending write is dropped (imem_we deasserts immediately).

Optional Feature:
- Macro: INSTR_ENCODER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], the XOR of all words written since start.
  - checksum is cleared on start and reset, and is valid when done pulses.
- Undefined: the checksum port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg holds:
  - 7-bit opcode constants (OPC_LOAD, OPC_STORE, OPC_OP, OPC_BRANCH, OPC_OP_IMM, OPC_JAL, OPC_JALR).
  - The 3-bit instr_kind_t enum.
  - The state enum.
  - Immediate range constants.
- The decoder imports the same opcode constants.
- One combinational sub-module, instr_pack: fields + kind -> 32-bit word plus an illegal flag. The FSM, address counter and output register stay in instr_encoder.

Test Plan:
- start; OP_IMM rd=1 rs1=0 f3=000 imm=5 -> write addr 0, data 0x00500093. Then LOAD rd=2 rs1=1 f3=010 imm=4 with last -> addr 1, data 0x0040A103; done pulses; count = 2.
- STORE rs1=0 rs2=2 f3=010 imm=8 -> 0x00202423. OP rd=3 rs1=1 rs2=2 sub=1 -> 0x402081B3.
- BRANCH rs1=1 rs2=2 f3=000 imm=-4 -> 0xFE208EE3. JAL rd=1 imm=8 -> 0x008000EF. Both written on consecutive cycles with no bubble.
- BRANCH imm=3, and separately OP_IMM imm=2048 -> no write, err = 1, in_ready = 0. Then start -> err cleared and count = 0.
- ADDR_WIDTH=2, four non-last beats -> 4 writes at addrs 0..3, then err = 1. Reset asserted mid-LOAD with in_valid high -> imem_we = 0 immediately; state IDLE after reset release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, request kinds and encoder state encoding.
// Imported by the instruction encoder and the core's decoder.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    KIND_LOAD    = 3'd0,
    KIND_STORE   = 3'd1,
    KIND_OP      = 3'd2,
    KIND_BRANCH  = 3'd3,
    KIND_OP_IMM  = 3'd4,
    KIND_JAL     = 3'd5,
    KIND_JALR    = 3'd6,
    KIND_ILLEGAL = 3'd7
  } instr_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } enc_state_t;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction fields plus kind -> 32-bit RV32I word.
// Flags illegal kinds and immediates that are out of range or misaligned.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        sub,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (instr_kind_t'(kind))
      KIND_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        illegal = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      KIND_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        illegal = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      KIND_OP: begin
        word = {1'b0, sub, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
      end
      KIND_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        illegal = !imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
      end
      KIND_OP_IMM: begin
        word    = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
        illegal = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      KIND_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        illegal = !imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
      end
      KIND_JALR: begin
        // funct3 is fixed at 000 for jalr regardless of the request
        word    = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
        illegal = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes request beats and writes them sequentially to imem.
// Optional XOR checksum of written words under INSTR_ENCODER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting beats, one registered write per legal beat
// FLUSH | final write on the port, no more beats
// DONE  | one-cycle done pulse
// ERR   | sticky error, waiting for start
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_kind,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic                  in_sub,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef INSTR_ENCODER_CHECKSUM_EN
  output logic [31:0]           checksum,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

  enc_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic                  err_q;

  logic [31:0]           word;
  logic                  illegal;
  logic                  accept;
  logic                  legal_accept;
  logic                  bad_accept;
  logic                  wrap_hit;
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] beat_addr;

  instr_pack u_pack (
    .kind    (in_kind),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .sub     (in_sub),
    .imm     (in_imm),
    .word    (word),
    .illegal (illegal)
  );

  assign accept       = in_valid && (state == ST_LOAD);
  assign legal_accept = accept && !illegal;
  assign bad_accept   = accept && illegal;
  // a write still on the port has not advanced addr yet
  assign beat_addr    = we_q ? addr_q + 1'b1 : addr_q;
  assign wrap_hit     = legal_accept && !in_last && (beat_addr == ADDR_TOP);
  assign load_start   = start && ((state == ST_IDLE) || (state == ST_ERR));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (bad_accept || wrap_hit)         state_nxt = ST_ERR;
        else if (legal_accept && in_last)   state_nxt = ST_FLUSH;
      end
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ERR:   if (start) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      we_q  <= legal_accept;
      if (legal_accept) wdata_q <= word;
      if (load_start) begin
        addr_q  <= BASE;
        count_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (we_q) begin
          // addr saturates at the top word instead of wrapping
          if (addr_q != ADDR_TOP) addr_q <= addr_q + 1'b1;
          count_q <= count_q + 1'b1;
        end
        if (bad_accept || wrap_hit) err_q <= 1'b1;
      end
    end
  end

`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           csum_q <= '0;
    else if (load_start) csum_q <= '0;
    else if (we_q)       csum_q <= csum_q ^ wdata_q;
  end
  assign checksum = csum_q;
`endif

  assign in_ready   = (state == ST_LOAD);
  assign busy       = (state == ST_LOAD) || (state == ST_FLUSH);
  assign done       = (state == ST_DONE);
  assign err        = err_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table plus hand-written sequences.
// Instance b uses ADDR_WIDTH=2 for the address-exhaustion and reset cases.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        sub;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        bad;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic in_valid = 1'b0;
  logic [2:0] in_kind = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0] in_funct3 = '0;
  logic in_sub = 1'b0;
  logic [31:0] in_imm = '0;
  logic in_last = 1'b0;

  logic in_ready_a, imem_we_a, busy_a, done_a, err_a;
  logic [7:0] imem_addr_a;
  logic [31:0] imem_wdata_a;
  logic [8:0] count_a;
  logic in_ready_b, imem_we_b, busy_b, done_b, err_b;
  logic [1:0] imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [2:0] count_b;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0] checksum_a, checksum_b;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt_a = 0;
  logic [31:0] wq_data_a[$];
  logic [7:0]  wq_addr_a[$];
  int          wq_cyc_a[$];
  logic [1:0]  wq_addr_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_sub(in_sub), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
    .busy(busy_a), .done(done_a), .err(err_a),
`ifdef INSTR_ENCODER_CHECKSUM_EN
    .checksum(checksum_a),
`endif
    .count(count_a)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_sub(in_sub), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
    .busy(busy_b), .done(done_b), .err(err_b),
`ifdef INSTR_ENCODER_CHECKSUM_EN
    .checksum(checksum_b),
`endif
    .count(count_b)
  );

  always @(negedge clk) begin
    if (imem_we_a) begin
      wq_data_a.push_back(imem_wdata_a);
      wq_addr_a.push_back(imem_addr_a);
      wq_cyc_a.push_back(cyc);
    end
    if (imem_we_b) wq_addr_b.push_back(imem_addr_b);
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit sel, input vec_t v, input logic last);
    int waited;
    in_kind = v.kind; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_sub = v.sub; in_imm = v.imm; in_last = last;
    in_valid = 1'b1;
    waited = 0;
    while (((sel ? in_ready_b : in_ready_a) !== 1'b1) && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      n_vec++;
      n_bad++;
      $display("FAIL send timeout: in_ready never rose within %0d cycles", waited);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  function automatic vec_t mk(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic sub,
                              input logic [31:0] imm, input logic [31:0] exp, input logic bad);
    vec_t v;
    v.kind = kind; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.sub = sub;
    v.imm = imm; v.exp = exp; v.bad = bad;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    int base;
    int d0;
    //            kind  rd  rs1 rs2 f3  sub imm            expected       bad
    tbl[0]  = mk(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5,        32'h00500093, 1'b0);
    tbl[1]  = mk(3'd0, 5'd2, 5'd1, 5'd0, 3'd2, 1'b0, 32'd4,        32'h0040A103, 1'b0);
    tbl[2]  = mk(3'd1, 5'd0, 5'd0, 5'd2, 3'd2, 1'b0, 32'd8,        32'h00202423, 1'b0);
    tbl[3]  = mk(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,        32'h402081B3, 1'b0);
    tbl[4]  = mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    tbl[5]  = mk(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,        32'h008000EF, 1'b0);
    tbl[6]  = mk(3'd6, 5'd1, 5'd5, 5'd0, 3'd7, 1'b0, 32'hFFFFFFFF, 32'hFFF280E7, 1'b0);
    tbl[7]  = mk(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2047,     32'h7FF00093, 1'b0);
    tbl[8]  = mk(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF800, 32'h80000093, 1'b0);
    tbl[9]  = mk(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1048574,  32'h7FFFF06F, 1'b0);
    tbl[10] = mk(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF000, 32'h80000063, 1'b0);
    tbl[11] = mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3,        32'h0, 1'b1);
    tbl[12] = mk(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,     32'h0, 1'b1);
    tbl[13] = mk(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0,        32'h0, 1'b1);
    tbl[14] = mk(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1048576,  32'h0, 1'b1);
    tbl[15] = mk(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096,     32'h0, 1'b1);
    tbl[16] = mk(3'd1, 5'd0, 5'd0, 5'd2, 3'd2, 1'b0, 32'hFFFFF7FF, 32'h0, 1'b1);

    #3;
    chk("rst in_ready", in_ready_a, 0);
    chk("rst imem_we", imem_we_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst err", err_a, 0);
    chk("rst addr", imem_addr_a, 0);
    chk("rst wdata", imem_wdata_a, 0);
    chk("rst count", count_a, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // one-beat program per table entry
    for (int i = 0; i < 17; i++) begin
      base = wq_data_a.size();
      d0 = done_cnt_a;
      pulse_start(1'b0);
      send(1'b0, tbl[i], 1'b1);
      tick(); tick(); tick();
      if (!tbl[i].bad) begin
        chk($sformatf("vec%0d writes", i), wq_data_a.size() - base, 1);
        if (wq_data_a.size() > base) begin
          chk($sformatf("vec%0d data", i), wq_data_a[base], tbl[i].exp);
          chk($sformatf("vec%0d addr", i), wq_addr_a[base], 0);
        end
        chk($sformatf("vec%0d done", i), done_cnt_a - d0, 1);
        chk($sformatf("vec%0d err", i), err_a, 0);
      end else begin
        chk($sformatf("vec%0d writes", i), wq_data_a.size() - base, 0);
        chk($sformatf("vec%0d err", i), err_a, 1);
        chk($sformatf("vec%0d in_ready", i), in_ready_a, 0);
        chk($sformatf("vec%0d done", i), done_cnt_a - d0, 0);
      end
    end

    // two-beat program: addresses, done and count
    base = wq_data_a.size();
    d0 = done_cnt_a;
    pulse_start(1'b0);
    chk("start clears err", err_a, 0);
    chk("start clears count", count_a, 0);
    send(1'b0, tbl[0], 1'b0);
    send(1'b0, tbl[1], 1'b1);
    tick(); tick(); tick();
    chk("prog writes", wq_data_a.size() - base, 2);
    if (wq_data_a.size() >= base + 2) begin
      chk("prog w0 addr", wq_addr_a[base], 0);
      chk("prog w0 data", wq_data_a[base], 32'h00500093);
      chk("prog w1 addr", wq_addr_a[base+1], 1);
      chk("prog w1 data", wq_data_a[base+1], 32'h0040A103);
    end
    chk("prog done", done_cnt_a - d0, 1);
    chk("prog count", count_a, 2);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("prog checksum", checksum_a, 32'h00500093 ^ 32'h0040A103);
`endif

    // four back-to-back beats: no bubble between writes
    base = wq_data_a.size();
    pulse_start(1'b0);
    send(1'b0, tbl[2], 1'b0);
    send(1'b0, tbl[3], 1'b0);
    send(1'b0, tbl[4], 1'b0);
    send(1'b0, tbl[5], 1'b1);
    tick(); tick(); tick();
    chk("b2b writes", wq_data_a.size() - base, 4);
    if (wq_data_a.size() >= base + 4) begin
      chk("b2b d0", wq_data_a[base],   32'h00202423);
      chk("b2b d1", wq_data_a[base+1], 32'h402081B3);
      chk("b2b d2", wq_data_a[base+2], 32'hFE208EE3);
      chk("b2b d3", wq_data_a[base+3], 32'h008000EF);
      chk("b2b a3", wq_addr_a[base+3], 3);
      for (int k = 0; k < 3; k++)
        chk($sformatf("b2b gap%0d", k), wq_cyc_a[base+k+1] - wq_cyc_a[base+k], 1);
    end
    chk("b2b count", count_a, 4);

    // error right behind a legal beat: in-flight write completes, nothing more
    base = wq_data_a.size();
    pulse_start(1'b0);
    send(1'b0, tbl[0], 1'b0);
    send(1'b0, tbl[11], 1'b0);
    tick(); tick();
    chk("err inflight writes", wq_data_a.size() - base, 1);
    chk("err flag", err_a, 1);
    chk("err in_ready", in_ready_a, 0);
    chk("err busy", busy_a, 0);
    chk("err count", count_a, 1);
    start_a = 1'b1;
    #1;
    chk("err start ignored-before-edge", err_a, 1);
    tick();
    start_a = 1'b0;
    chk("restart err", err_a, 0);
    chk("restart count", count_a, 0);
    chk("restart in_ready", in_ready_a, 1);
    send(1'b0, tbl[1], 1'b1);
    tick(); tick(); tick();

    // start ignored while loading
    base = wq_data_a.size();
    pulse_start(1'b0);
    send(1'b0, tbl[0], 1'b0);
    start_a = 1'b1;
    send(1'b0, tbl[7], 1'b1);
    start_a = 1'b0;
    tick(); tick(); tick();
    chk("ign start w1 addr", (wq_addr_a.size() >= base + 2) ? wq_addr_a[base+1] : 8'hFF, 1);
    chk("ign start count", count_a, 2);

    // ADDR_WIDTH=2: four non-last beats fill memory then raise err
    base = wq_addr_b.size();
    pulse_start(1'b1);
    for (int k = 0; k < 4; k++) send(1'b1, tbl[0], 1'b0);
    tick(); tick(); tick();
    chk("wrap writes", wq_addr_b.size() - base, 4);
    if (wq_addr_b.size() >= base + 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("wrap addr%0d", k), wq_addr_b[base+k], k);
    chk("wrap err", err_b, 1);
    chk("wrap in_ready", in_ready_b, 0);
    chk("wrap addr held", imem_addr_b, 3);
    chk("wrap count", count_b, 4);

    // reset mid-LOAD with a write pending and in_valid held
    pulse_start(1'b1);
    in_kind = 3'd4; in_imm = 32'd1; in_last = 1'b0; in_valid = 1'b1;
    tick();
    chk("mid pending we", imem_we_b, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid reset we", imem_we_b, 0);
    chk("mid reset in_ready", in_ready_b, 0);
    base = wq_addr_b.size();
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    chk("post reset busy", busy_b, 0);
    chk("post reset in_ready", in_ready_b, 0);
    chk("post reset count", count_b, 0);
    chk("post reset addr", imem_addr_b, 0);
    chk("post reset no write", wq_addr_b.size() - base, 0);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
